// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: one partial product per cycle from a
// barrel left shifter, yielding (a*b) mod 2^data_width after a fixed 9-cycle latency.

module left_shifter #(
    parameter int data_width = 8,
    parameter int shift_len  = 3
) (
    input  logic [data_width-1:0] data_in,
    input  logic [shift_len-1:0]  bits,
    output logic [data_width-1:0] data_out
);
    logic [data_width-1:0] stage_v;

    // Log-depth barrel: stage i shifts by 2**i when bits[i] is set.
    always_comb begin
        stage_v = data_in;
        for (int i = 0; i < shift_len; i++) begin
            if (bits[i]) begin
                stage_v = stage_v << (1 << i);
            end
        end
        data_out = stage_v;
    end
endmodule

module shift_add_mult #(
    parameter int data_width = 8,
    parameter int shift_len  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [shift_len-1:0] LAST_BIT = shift_len'(data_width - 1);

    state_t                state_q,   state_d;
    logic [data_width-1:0] a_q,       a_d;
    logic [data_width-1:0] b_q,       b_d;
    logic [data_width-1:0] acc_q,     acc_d;
    logic [data_width-1:0] product_q, product_d;
    logic [shift_len-1:0]  cnt_q,     cnt_d;

    logic [data_width-1:0] shifted;
    logic [data_width-1:0] partial;
    logic [data_width-1:0] sum;

    left_shifter #(
        .data_width(data_width),
        .shift_len (shift_len)
    ) u_left_shifter (
        .data_in (a_q),
        .bits    (cnt_q),
        .data_out(shifted)
    );

    assign partial = b_q[cnt_q] ? shifted : '0;
    assign sum     = acc_q + partial;   // carry-out intentionally dropped

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = sum;
                if (cnt_q == LAST_BIT) begin
                    state_d   = DONE;
                    product_d = sum;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized bench for shift_add_mult: per-cycle comparison against a
// countdown/queue-free behavioural model, plus directed literal cases.

module tb_shift_add_mult;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    shift_add_mult #(
        .data_width(8),
        .shift_len (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (op_a),
        .b      (op_b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted start books a result (a*b mod 256)
    // that appears 8 edges later; reset cancels everything.
    int         m_rem  = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_prod = 8'h00;
    logic [7:0] m_pend = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_prod <= 8'h00;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) m_prod <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= 8'((int'(op_a) * int'(op_b)) % 256);
                m_rem  <= 8;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_busy", int'(busy), int'(m_rem > 0));
            check("cyc_done", int'(done), int'(m_done));
            check("cyc_product", int'(product), int'(m_prod));
        end
    end

    // One operation from idle. poke_mask bit n forces a start with a=b=0xFF
    // in RUN cycle n; noise adds random starts during RUN cycles 2..7.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic [7:0] exp, input logic [15:0] poke_mask,
                          input bit noise);
        int lat = 0;
        int busy_cnt = 0;
        logic [7:0] got = 8'h00;
        @(posedge clk); #1;
        op_a = ta; op_b = tb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (poke_mask[n]) begin
                start = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
            end else if (noise && n >= 2 && n <= 7) begin
                start = ($urandom_range(0, 2) == 0);
                op_a  = 8'($urandom); op_b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = n;
                got = product;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("latency", lat, 9);
        check("busy_cycles", busy_cnt, 8);
        check("product", int'(got), int'(exp));
        repeat (2) @(negedge clk);
        check("product_hold", int'(product), int'(exp));
        $display("op a=%02h b=%02h product=%02h expected=%02h latency=%0d", ta, tb, got, exp, lat);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int bad;
        int dc;
        rst = 1'b1; start = 1'b0; op_a = 8'h00; op_b = 8'h00;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_product", int'(product), 0);

        // Hand-computed cases
        run_op(8'd3,   8'd5,   8'h0F, 16'h0, 1'b0);
        run_op(8'hFF,  8'hFF,  8'h01, 16'h0, 1'b0);
        run_op(8'h10,  8'h10,  8'h00, 16'h0, 1'b0);
        run_op(8'h00,  8'hA5,  8'h00, 16'h0, 1'b0);
        run_op(8'd7,   8'd9,   8'h3F, 16'b0000_0000_0010_0100, 1'b0);

        // Start held high: a result every 9 cycles, busy low only when done
        dones = 0; bad = 0;
        @(posedge clk); #1;
        op_a = 8'd2; op_b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 36; n++) begin
            start = (n < 36);
            @(negedge clk);
            if (busy == done) bad++;
            if (done) begin
                dones++;
                check("held_done_pos", n % 9, 0);
                check("held_product", int'(product), 8'h06);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("held_done_count", dones, 4);
        check("held_busy_pattern", bad, 0);
        $display("held a=02 b=03 dones=%0d", dones);

        // Reset during RUN cycle 4 aborts the operation
        @(posedge clk); #1;
        op_a = 8'd5; op_b = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_product", int'(product), 0);
        dc = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("abort_no_done", dc, 0);
        $display("abort a=05 b=06 late_dones=%0d", dc);
        run_op(8'd5, 8'd6, 8'h1E, 16'h0, 1'b0);

        // Random operations with random gaps and ignored starts during RUN
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(ra, rb, 8'((int'(ra) * int'(rb)) % 256), 16'h0, 1'b1);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
